digits_to_byte: RTL and testbench

- Serial decimal-to-binary converter; the inverse of the binary-to-digit serializer on the output path.
- Sits on the RPN input path. It takes BCD digits decoded from UART characters, most significant digit first, one per cycle strobe. On an end-of-number strobe it emits the accumulated unsigned binary value.
- Tracks digit count, overflow and illegal-digit conditions so the operand parser can reject bad input.

---
 rtl/digits_to_byte_if.sv | 26 ++
 rtl/digits_to_byte.sv | 129 ++++++++++++
 tb/tb_digits_to_byte.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/digits_to_byte_if.sv
// Handshake bundle between the UART digit decoder and the decimal-to-binary converter.
// The master side strobes digits and control; the slave side returns the result and status.
interface digits_to_byte_if #(
   parameter int WIDTH = 16
);
   logic [3:0]       din;
   logic             wen;
   logic             fin;
   logic             clr;
   logic [WIDTH-1:0] dout;
   logic             valid;
   logic             overflow;
   logic             bad_digit;
   logic [2:0]       ndigits;
   logic             busy;

   modport master (
      output din, wen, fin, clr,
      input  dout, valid, overflow, bad_digit, ndigits, busy
   );

   modport slave (
      input  din, wen, fin, clr,
      output dout, valid, overflow, bad_digit, ndigits, busy
   );
endinterface

// File: rtl/digits_to_byte.sv
// Serial BCD (most significant digit first) to unsigned binary converter with
// digit count, saturation/overflow and illegal-digit tracking for the RPN operand parser.
module digits_to_byte #(
   parameter int WIDTH      = 16,
   parameter int MAX_DIGITS = 5
) (
   input logic              clk,
   input logic              rst,
   digits_to_byte_if.slave  bus
);
   localparam int AW = WIDTH + 4;
   localparam logic [AW-1:0]    MAX_WIDE = AW'({WIDTH{1'b1}});
   localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
   localparam logic [2:0]       ND_MAX   = 3'(MAX_DIGITS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      EMIT  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [2:0]       nd_q, nd_d;
   logic             ovf_q, ovf_d;
   logic             bad_q, bad_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             valid_q, valid_d;
   logic             overflow_q, overflow_d;
   logic             bad_digit_q, bad_digit_d;
   logic             busy_q, busy_d;
   logic [AW-1:0]    next_s;
   logic             digit_ok_s;

   // Next-state: digit absorption first, then end-of-number capture; clr overrides both.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      nd_d        = nd_q;
      ovf_d       = ovf_q;
      bad_d       = bad_q;
      dout_d      = dout_q;
      valid_d     = 1'b0;
      overflow_d  = overflow_q;
      bad_digit_d = bad_digit_q;
      busy_d      = busy_q;
      next_s      = AW'(acc_q) * AW'(4'd10) + AW'(bus.din);
      digit_ok_s  = (bus.din <= 4'd9);

      if (bus.clr) begin
         state_d = IDLE;
         acc_d   = {WIDTH{1'b0}};
         nd_d    = 3'd0;
         ovf_d   = 1'b0;
         bad_d   = 1'b0;
      end else begin
         if (bus.wen) begin
            state_d = ACCUM;
         end else if (state_q == EMIT) begin
            state_d = IDLE;
         end else begin
            state_d = state_q;
         end

         // Once saturated, further digits only keep the overflow flag set.
         if (bus.wen && !digit_ok_s) begin
            bad_d = 1'b1;
         end else if (bus.wen && !ovf_q && (next_s > MAX_WIDE || nd_q == ND_MAX)) begin
            acc_d = MAX_VAL;
            ovf_d = 1'b1;
         end else if (bus.wen && !ovf_q) begin
            acc_d = next_s[WIDTH-1:0];
            nd_d  = nd_q + 3'd1;
         end else begin
            acc_d = acc_q;
         end

         if (bus.fin) begin
            dout_d      = acc_d;
            overflow_d  = ovf_d;
            bad_digit_d = bad_d;
            valid_d     = 1'b1;
            acc_d       = {WIDTH{1'b0}};
            nd_d        = 3'd0;
            ovf_d       = 1'b0;
            bad_d       = 1'b0;
            state_d     = EMIT;
         end else begin
            valid_d = 1'b0;
         end
      end

      busy_d = (state_d == ACCUM);
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= {WIDTH{1'b0}};
         nd_q        <= 3'd0;
         ovf_q       <= 1'b0;
         bad_q       <= 1'b0;
         dout_q      <= {WIDTH{1'b0}};
         valid_q     <= 1'b0;
         overflow_q  <= 1'b0;
         bad_digit_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         nd_q        <= nd_d;
         ovf_q       <= ovf_d;
         bad_q       <= bad_d;
         dout_q      <= dout_d;
         valid_q     <= valid_d;
         overflow_q  <= overflow_d;
         bad_digit_q <= bad_digit_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.dout      = dout_q;
   assign bus.valid     = valid_q;
   assign bus.overflow  = overflow_q;
   assign bus.bad_digit = bad_digit_q;
   assign bus.ndigits   = nd_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_digits_to_byte.sv
// Directed bench for digits_to_byte: expected results are queued when fin is driven
// and compared against each valid pulse.
module tb_digits_to_byte;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   typedef struct {
      logic [15:0] d;
      logic        o;
      logic        b;
   } exp_t;

   exp_t sb[$];

   digits_to_byte_if #(.WIDTH(16)) bus ();

   digits_to_byte #(.WIDTH(16), .MAX_DIGITS(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock of stimulus; any valid pulse is matched against the scoreboard.
   task automatic drive(input logic [3:0] d, input logic w, input logic f, input logic c);
      exp_t e;
      bus.din = d;
      bus.wen = w;
      bus.fin = f;
      bus.clr = c;
      @(posedge clk);
      #1;
      bus.wen = 1'b0;
      bus.fin = 1'b0;
      bus.clr = 1'b0;
      chk("valid", bus.valid, f && !c);
      if (bus.valid === 1'b1 && sb.size() > 0) begin
         e = sb.pop_front();
         chk("dout", bus.dout, e.d);
         chk("overflow", bus.overflow, e.o);
         chk("bad_digit", bus.bad_digit, e.b);
      end
   endtask

   task automatic digit(input logic [3:0] d);
      drive(d, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic push(input logic [15:0] v, input logic o, input logic b);
      exp_t e;
      e.d = v;
      e.o = o;
      e.b = b;
      sb.push_back(e);
   endtask

   task automatic fin_exp(input logic [15:0] v, input logic o, input logic b);
      push(v, o, b);
      drive(4'd0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      bus.din = 4'd0;
      bus.wen = 1'b0;
      bus.fin = 1'b0;
      bus.clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dout", bus.dout, 32'd0);
      chk("rst_valid", bus.valid, 32'd0);
      chk("rst_busy", bus.busy, 32'd0);
      chk("rst_ndigits", bus.ndigits, 32'd0);
      rst = 1'b0;

      // 65535 exactly fits
      digit(4'd6); digit(4'd5); digit(4'd5); digit(4'd3); digit(4'd5);
      chk("nd_full", bus.ndigits, 32'd5);
      chk("busy_accum", bus.busy, 32'd1);
      fin_exp(16'd65535, 1'b0, 1'b0);
      chk("nd_after_fin", bus.ndigits, 32'd0);
      chk("busy_after_fin", bus.busy, 32'd0);

      // reset mid-number clears outputs asynchronously
      digit(4'd1); digit(4'd2);
      chk("nd_two", bus.ndigits, 32'd2);
      rst = 1'b1;
      #2;
      chk("mid_rst_dout", bus.dout, 32'd0);
      chk("mid_rst_busy", bus.busy, 32'd0);
      chk("mid_rst_nd", bus.ndigits, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      fin_exp(16'd0, 1'b0, 1'b0);

      // value overflow and digit-count overflow
      digit(4'd6); digit(4'd5); digit(4'd5); digit(4'd3); digit(4'd6);
      fin_exp(16'd65535, 1'b1, 1'b0);
      digit(4'd1);
      for (int i = 0; i < 5; i++) digit(4'd0);
      fin_exp(16'd65535, 1'b1, 1'b0);

      // leading zeros counted
      digit(4'd0); digit(4'd0); digit(4'd0); digit(4'd4); digit(4'd2);
      chk("nd_lead_zero", bus.ndigits, 32'd5);
      fin_exp(16'd42, 1'b0, 1'b0);

      // illegal digit ignored but flagged
      digit(4'd4); digit(4'hA);
      chk("busy_bad", bus.busy, 32'd1);
      chk("nd_bad", bus.ndigits, 32'd1);
      digit(4'd2);
      fin_exp(16'd42, 1'b0, 1'b1);

      // digit strobed together with fin is absorbed first
      digit(4'd3);
      push(16'd37, 1'b0, 1'b0);
      drive(4'd7, 1'b1, 1'b1, 1'b0);

      // back-to-back: digit during EMIT starts the next number
      digit(4'd1); digit(4'd2);
      fin_exp(16'd12, 1'b0, 1'b0);
      digit(4'd9);
      fin_exp(16'd9, 1'b0, 1'b0);

      // clr aborts without emitting; dout held
      digit(4'd8); digit(4'd8);
      drive(4'd0, 1'b0, 1'b0, 1'b1);
      chk("clr_dout_held", bus.dout, 32'd9);
      chk("clr_nd", bus.ndigits, 32'd0);
      chk("clr_busy", bus.busy, 32'd0);
      digit(4'd5);
      fin_exp(16'd5, 1'b0, 1'b0);

      // clr wins over fin
      digit(4'd3);
      drive(4'd0, 1'b0, 1'b1, 1'b1);
      chk("clrfin_dout", bus.dout, 32'd5);
      fin_exp(16'd0, 1'b0, 1'b0);

      // fin held two cycles emits twice, second is zero
      digit(4'd2);
      fin_exp(16'd2, 1'b0, 1'b0);
      fin_exp(16'd0, 1'b0, 1'b0);

      drive(4'd0, 1'b0, 1'b0, 1'b0);
      chk("sb_empty", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
